// File: rtl/serial_bit_feeder_pkg.sv
// -----------------------------------------------------------------------------
// serial_bit_feeder_pkg
//
// Shared definitions for the serial bit feeders and the single-bit sequence
// detectors they drive.
//   feeder_state_e : feeder FSM state encoding (IDLE / SHIFT / PARITY)
//   cnt_width()    : width of a bit counter that indexes 0..width-1
// -----------------------------------------------------------------------------
package serial_bit_feeder_pkg;

   // PARITY is only reachable when the parity beat is compiled in
   // (FEEDER_PARITY_EN). The encoding stays fixed so that every build of a
   // feeder reports the same state codes.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_SHIFT  = 2'b01,
      ST_PARITY = 2'b10
   } feeder_state_e;

   // Counter that indexes bits 0..width-1. Widths of 2 and above give
   // $clog2(width) >= 1. The guard keeps a degenerate width from producing a
   // zero-width vector.
   function automatic int cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage : serial_bit_feeder_pkg

// File: rtl/serial_bit_feeder.sv
// -----------------------------------------------------------------------------
// serial_bit_feeder
//
// Parallel-to-serial feeder for the single-bit Mealy sequence detectors.
// It accepts one WIDTH-bit word over a valid/ready handshake. It then
// presents the word one bit per enabled clock on `out`.
//
// Parameters
//   WIDTH     : word width in bits (>= 2)
//   MSB_FIRST : 1 = bit WIDTH-1 first, 0 = bit 0 first
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   data_in    in   parallel word to serialize
//   data_valid in   data_in holds a word
//   data_ready out  a word is accepted this cycle if data_valid is high
//   en         in   bit-rate enable, one bit is consumed per cycle with en=1
//   out        out  current serial bit (drives the detector's `in`)
//   out_valid  out  out is a real bit and is consumed this cycle
//   word_done  out  pulse on the cycle the final beat of a word is consumed
//   busy       out  a word is in flight
//
// Build option
//   FEEDER_PARITY_EN : when defined, each word is followed by one even-parity
//                      beat (XOR of the captured word). word_done and the
//                      back-to-back ready window move to that beat.
// -----------------------------------------------------------------------------
module serial_bit_feeder
   import serial_bit_feeder_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_valid,
   output logic             data_ready,
   input  logic             en,
   output logic             out,
   output logic             out_valid,
   output logic             word_done,
   output logic             busy
);

   localparam int             CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);

   feeder_state_e    state_q;
   logic [WIDTH-1:0] shreg_q;
   logic [CW-1:0]    cnt_q;
`ifdef FEEDER_PARITY_EN
   logic             parity_q;
`endif

   logic [WIDTH-1:0] shreg_shifted;
   logic             head_bit;
   logic             shift_beat;
   logic             last_data_beat;
   logic             done_beat;
   logic             load;

   // One-position shift toward the output end, zero fill at the far end.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_shift
         if (MSB_FIRST) begin : g_msb
            if (gi == 0) begin : g_fill
               assign shreg_shifted[gi] = 1'b0;
            end else begin : g_move
               assign shreg_shifted[gi] = shreg_q[gi-1];
            end
         end else begin : g_lsb
            if (gi == WIDTH - 1) begin : g_fill
               assign shreg_shifted[gi] = 1'b0;
            end else begin : g_move
               assign shreg_shifted[gi] = shreg_q[gi+1];
            end
         end
      end
   endgenerate

   assign head_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

   always_comb begin
      shift_beat     = (state_q == ST_SHIFT) && en;
      last_data_beat = shift_beat && (cnt_q == LAST_IDX);
`ifdef FEEDER_PARITY_EN
      done_beat      = (state_q == ST_PARITY) && en;
`else
      done_beat      = last_data_beat;
`endif
      // Ready is also high on the final consumed beat. A word that is
      // waiting can then follow with no idle bubble.
      data_ready     = (state_q == ST_IDLE) || done_beat;
      load           = data_valid && data_ready;
   end

   // Outputs come from register state only. They do not depend on
   // data_valid or data_in, so the path into the detector stays short.
   always_comb begin
      out = 1'b0;
      unique case (state_q)
         ST_SHIFT:  out = head_bit;
`ifdef FEEDER_PARITY_EN
         ST_PARITY: out = parity_q;
`endif
         default:   out = 1'b0;
      endcase
   end

`ifdef FEEDER_PARITY_EN
   assign out_valid = ((state_q == ST_SHIFT) || (state_q == ST_PARITY)) && en;
`else
   assign out_valid = shift_beat;
`endif
   assign word_done = done_beat;
   assign busy      = (state_q != ST_IDLE);

   // FSM, bit counter and shifter. A load takes priority over advancing.
   // This is what lets the next word replace the final beat of the current
   // one.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         shreg_q  <= '0;
         cnt_q    <= '0;
`ifdef FEEDER_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else if (load) begin
         state_q  <= ST_SHIFT;
         shreg_q  <= data_in;
         cnt_q    <= '0;
`ifdef FEEDER_PARITY_EN
         parity_q <= ^data_in;
`endif
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               state_q <= ST_IDLE;
            end
            ST_SHIFT: begin
               if (en) begin
                  shreg_q <= shreg_shifted;
                  if (last_data_beat) begin
                     cnt_q   <= '0;
`ifdef FEEDER_PARITY_EN
                     state_q <= ST_PARITY;
`else
                     state_q <= ST_IDLE;
`endif
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
            end
`ifdef FEEDER_PARITY_EN
            ST_PARITY: begin
               if (en) begin
                  state_q <= ST_IDLE;
               end
            end
`endif
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule : serial_bit_feeder

// File: doc/serial_bit_feeder.md
Name: serial_bit_feeder

Overview:
Parallel-to-serial feeder that sits directly upstream of the team's single-bit Mealy sequence detectors. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per enabled clock on `out`, which drives the detector's `in`. `out_valid` marks the cycles in which a bit is presented, so the downstream stage can qualify its sampling.

Parameters:
WIDTH, 8, word width in bits; legal values are 2 and above.
MSB_FIRST, 1, selects shift order: 1 = bit WIDTH-1 first, 0 = bit 0 first.

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  synchronous active-high reset
data_in  input  WIDTH  parallel word to serialize
data_valid  input  1  data_in holds a word
data_ready  output  1  feeder will accept a word this cycle
en  input  1  bit-rate enable; the feeder advances one bit per cycle with en=1
out  output  1  current serial bit (feeds detector `in`)
out_valid  output  1  out is a real bit and is consumed this cycle
word_done  output  1  one-cycle pulse on the cycle the final bit of a word is consumed
busy  output  1  word in flight (state != IDLE)

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: state=IDLE, shift register=0, bit counter=0. Resulting outputs: out=0, out_valid=0, word_done=0, busy=0, data_ready=1.
- States:
  - IDLE: no word held.
  - SHIFT: word being emitted.
  - PARITY: exists only with the optional feature.
- Bit counter width is $clog2(WIDTH). It counts consumed bits 0..WIDTH-1.
- Transfer occurs when data_valid && data_ready at a rising edge:
  - data_in is captured into the shift register, counter is cleared, state becomes SHIFT.
  - First bit appears on out in the next cycle (1-cycle latency).
- out is driven from register state only:
  - MSB_FIRST=1: shreg[WIDTH-1], shifting left with 0 fill.
  - MSB_FIRST=0: shreg[0], shifting right with 0 fill.
  - IDLE forces out=0.
- out_valid = (state==SHIFT) && en.
  - en=0 in SHIFT: out holds its bit, counter and shift register freeze, out_valid=0.
- Last bit: word_done = (state==SHIFT) && en && (cnt==WIDTH-1), combinational from registers.
- data_ready = (state==IDLE) || word_done-condition. This allows back-to-back words with no bubble:
  - data_valid on the last-bit cycle loads the next word and stays in SHIFT.
  - Otherwise the feeder goes to IDLE.
- data_in is ignored when data_ready=0. The word is held internally, so the source may change data_in after transfer.
- A word takes exactly WIDTH enabled cycles.
- Reset mid-word: the word is discarded, state=IDLE next cycle, and no word_done is issued.
- rst has priority over a simultaneous transfer.
- en=0 in IDLE: no effect. Loading does not depend on en.

Optional Feature:
Macro: FEEDER_PARITY_EN.
- Defined:
  - After the last data bit, state moves to PARITY and emits one even-parity bit (XOR of the captured word), gated by en like a data bit.
  - The word_done pulse and the last-bit data_ready window move from the last data bit to the PARITY beat.
  - A word takes WIDTH+1 enabled cycles.
  - Parity is computed at capture and stored in a 1-bit register.
- Undefined: no PARITY state and no parity register. Behaviour is exactly as described above.

Decomposition:
- Shared package/header holds the state encodings (IDLE=2'b00, SHIFT=2'b01, PARITY=2'b10) and the counter-width localparam derivation, for reuse by future feeders and detectors.
- No sub-module is needed; the block is a single module (counter, shifter and FSM inline).
- The bench instantiates serial_bit_feeder driving the detector, with out -> in.

Test Plan:
1. WIDTH=8, MSB_FIRST=1, en=1, load 8'hD0 → out=1,1,0,1,0,0,0,0 on cycles 1..8 after transfer; out_valid high for 8 cycles; word_done on cycle 8; the attached 1101 detector pulses y on bit 4.
2. Back-to-back 8'hD0 then 8'hB4 with data_valid held → 16 consecutive out_valid cycles with no gap; data_ready high only at IDLE, cycle 8 and cycle 16; two word_done pulses.
3. 8'hD0, en low on cycles 3-5 → out holds bit index 2 (0) for 3 cycles with out_valid=0; word_done arrives on cycle 11.
4. rst asserted after 3 bits of 8'hFF → next cycle out=0, out_valid=0, busy=0, data_ready=1; no word_done.
5. MSB_FIRST=0, load 8'h0B → out=1,1,0,1,0,0,0,0.
6. FEEDER_PARITY_EN defined, load 8'hD0 → 8 data bits then parity bit 1 on cycle 9; word_done on cycle 9; 8'hC0 gives parity 0.
